// File: rtl/uart_image_loader.sv
// Loads one grayscale frame from the UART byte receiver into image RAM, throttles the host via RTS,
// and holds the frame for the detector until img_done. Optional load abort: define UART_LOADER_TIMEOUT_EN.
module uart_image_loader #(
  parameter int IMG_BYTES      = 19200,
  parameter int ADDR_W         = 15,
  parameter int RTS_MARGIN     = 2,
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              uart_data_rdy,
  input  logic [7:0]        uart_data,
  output logic              fpga_can_receive,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              img_ready,
  input  logic              img_done,
  output logic              overrun,
  output logic [7:0]        frame_cnt,
  output logic              load_timeout
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(IMG_BYTES - 1);
  localparam logic [CNT_W-1:0] RTS_THR  = CNT_W'(IMG_BYTES - RTS_MARGIN);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          wdata_q, wdata_d;
  logic                ready_q, ready_d;
  logic                ovr_q, ovr_d;
  logic [7:0]          fcnt_q, fcnt_d;
  logic                rts_q, rts_d;
  logic                to_pulse_q, to_pulse_d;
`ifdef UART_LOADER_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0]         to_cnt_q, to_cnt_d;
`endif

  always_comb begin
    state_d    = state_q;
    wr_cnt_d   = wr_cnt_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ovr_d      = ovr_q;
    fcnt_d     = fcnt_q;
    to_pulse_d = 1'b0;
`ifdef UART_LOADER_TIMEOUT_EN
    to_cnt_d   = '0;
`endif
    case (state_q)
      IDLE: begin
        if (uart_data_rdy) begin
          we_d     = 1'b1;
          addr_d   = '0;
          wdata_d  = uart_data;
          wr_cnt_d = CNT_W'(1);
          if (IMG_BYTES == 1) begin
            state_d = HOLD;
            fcnt_d  = fcnt_q + 8'd1;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (uart_data_rdy) begin
          we_d     = 1'b1;
          addr_d   = wr_cnt_q[ADDR_W-1:0];
          wdata_d  = uart_data;
          wr_cnt_d = wr_cnt_q + CNT_W'(1);
          if (wr_cnt_q == LAST_IDX) begin
            state_d = HOLD;
            fcnt_d  = fcnt_q + 8'd1;
          end
        end
`ifdef UART_LOADER_TIMEOUT_EN
        else if (to_cnt_q == TO_LAST) begin
          state_d    = IDLE;
          wr_cnt_d   = '0;
          to_pulse_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 32'd1;
        end
`endif
      end
      HOLD: begin
        if (uart_data_rdy) ovr_d = 1'b1;
        if (img_done) begin
          state_d  = IDLE;
          wr_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    // Frame is presented from the cycle after the final write until img_done is sampled.
    ready_d = (state_q == HOLD) && (state_d == HOLD);
    // RTS uses the pre-write count so it drops one cycle after the threshold write's pulse.
    rts_d   = (state_d == IDLE) || ((state_d == LOAD) && (wr_cnt_q < RTS_THR));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_cnt_q   <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ready_q    <= 1'b0;
      ovr_q      <= 1'b0;
      fcnt_q     <= '0;
      rts_q      <= 1'b1;
      to_pulse_q <= 1'b0;
`ifdef UART_LOADER_TIMEOUT_EN
      to_cnt_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ready_q    <= ready_d;
      ovr_q      <= ovr_d;
      fcnt_q     <= fcnt_d;
      rts_q      <= rts_d;
      to_pulse_q <= to_pulse_d;
`ifdef UART_LOADER_TIMEOUT_EN
      to_cnt_q   <= to_cnt_d;
`endif
    end
  end

  assign fpga_can_receive = rts_q;
  assign mem_we           = we_q;
  assign mem_addr         = addr_q;
  assign mem_wdata        = wdata_q;
  assign img_ready        = ready_q;
  assign overrun          = ovr_q;
  assign frame_cnt        = fcnt_q;
  assign load_timeout     = to_pulse_q;

endmodule

// File: tb/tb_uart_image_loader.sv
// Randomized bench for uart_image_loader: a frame-level reference model predicts RAM writes (scoreboard)
// and the RTS / img_ready / overrun / frame_cnt levels after every transaction.
module tb_uart_image_loader;

  localparam int IMG_BYTES      = 4;
  localparam int ADDR_W         = 4;
  localparam int RTS_MARGIN     = 1;
  localparam int TIMEOUT_CYCLES = 100;
  localparam int RTS_THR        = IMG_BYTES - RTS_MARGIN;

  logic              clk = 1'b0;
  logic              reset;
  logic              uart_data_rdy;
  logic [7:0]        uart_data;
  logic              fpga_can_receive;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              img_ready;
  logic              img_done;
  logic              overrun;
  logic [7:0]        frame_cnt;
  logic              load_timeout;

  uart_image_loader #(
    .IMG_BYTES(IMG_BYTES), .ADDR_W(ADDR_W),
    .RTS_MARGIN(RTS_MARGIN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clock(clk), .reset(reset), .uart_data_rdy(uart_data_rdy), .uart_data(uart_data),
    .fpga_can_receive(fpga_can_receive), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .img_ready(img_ready), .img_done(img_done),
    .overrun(overrun), .frame_cnt(frame_cnt), .load_timeout(load_timeout)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // reference model state
  int  checks = 0;
  int  errors = 0;
  int  m_cnt = 0;
  bit  m_hold = 0;
  int  m_frames = 0;
  bit  m_ovr = 0;
  int  m_to_exp = 0;
  int  to_seen = 0;
  logic [ADDR_W+7:0] exp_q[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_levels(input string tag);
    chk({tag, "_rts"}, int'(fpga_can_receive), int'(!m_hold && (m_cnt < RTS_THR)));
    chk({tag, "_img_ready"}, int'(img_ready), int'(m_hold));
    chk({tag, "_frame_cnt"}, int'(frame_cnt), m_frames);
    chk({tag, "_overrun"}, int'(overrun), int'(m_ovr));
  endtask

  function automatic void model_byte(input logic [7:0] d);
    logic [ADDR_W-1:0] a;
    if (m_hold) begin
      m_ovr = 1'b1;
    end else begin
      a = ADDR_W'(m_cnt);
      exp_q.push_back({a, d});
      m_cnt++;
      if (m_cnt == IMG_BYTES) begin
        m_hold   = 1'b1;
        m_frames = (m_frames + 1) % 256;
      end
    end
  endfunction

  // driver tasks
  task automatic send_byte(input logic [7:0] d, input int gap);
    @(negedge clk);
    uart_data_rdy = 1'b1;
    uart_data     = d;
    model_byte(d);
    @(negedge clk);
    uart_data_rdy = 1'b0;
    @(negedge clk);
    check_levels("after_byte");
    repeat (gap) @(negedge clk);
  endtask

  task automatic pulse_done(input bit with_byte, input logic [7:0] d);
    @(negedge clk);
    img_done = 1'b1;
    if (with_byte) begin
      uart_data_rdy = 1'b1;
      uart_data     = d;
      if (m_hold) m_ovr = 1'b1;
    end
    if (m_hold) begin
      m_hold = 1'b0;
      m_cnt  = 0;
    end
    @(negedge clk);
    img_done      = 1'b0;
    uart_data_rdy = 1'b0;
    check_levels(with_byte ? "done_and_byte" : "after_done");
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
`ifdef UART_LOADER_TIMEOUT_EN
    if (!m_hold && m_cnt > 0 && n >= TIMEOUT_CYCLES + 2) begin
      m_cnt = 0;
      m_to_exp++;
    end
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_cnt = 0; m_hold = 0; m_frames = 0; m_ovr = 0;
    check_levels("reset");
    chk("reset_mem_we", int'(mem_we), 0);
    chk("reset_mem_addr", int'(mem_addr), 0);
    chk("reset_mem_wdata", int'(mem_wdata), 0);
    chk("reset_load_timeout", int'(load_timeout), 0);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [ADDR_W+7:0] e;
    if (mem_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0d data %02h with no write expected at %0t",
                 mem_addr, mem_wdata, $time);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", int'(mem_addr), int'(e[ADDR_W+7:8]));
        chk("write_data", int'(mem_wdata), int'(e[7:0]));
      end
    end
    if (load_timeout) to_seen++;
  end

  // stimulus
  initial begin
    reset = 1'b1; uart_data_rdy = 1'b0; uart_data = 8'h00; img_done = 1'b0;
    do_reset();

    // frame A with wide spacing, then a byte while held
    send_byte(8'hA1, 54); send_byte(8'hA2, 54); send_byte(8'hA3, 54); send_byte(8'hA4, 54);
    send_byte(8'h5F, 10);
    pulse_done(1'b0, 8'h00);
    send_byte(8'hB1, 3); send_byte(8'hB2, 3); send_byte(8'hB3, 3); send_byte(8'hB4, 3);

    // img_done outside HOLD is ignored; img_done with a byte in HOLD drops the byte
    pulse_done(1'b0, 8'h00);
    send_byte(8'h11, 2); send_byte(8'h22, 2);
    pulse_done(1'b0, 8'h00);
    send_byte(8'h33, 2); send_byte(8'h44, 2);
    pulse_done(1'b1, 8'h99);

    // randomized frames
    for (int f = 0; f < 8; f++) begin
      while (!m_hold) begin
        send_byte(8'($urandom_range(0, 255)), $urandom_range(0, 20));
        if (!m_hold && $urandom_range(0, 5) == 0) pulse_done(1'b0, 8'h00);
      end
      for (int k = 0; k < int'($urandom_range(0, 2)); k++)
        send_byte(8'($urandom_range(0, 255)), $urandom_range(0, 5));
      idle($urandom_range(0, 10));
      pulse_done($urandom_range(0, 1) == 1, 8'($urandom_range(0, 255)));
    end

    // stall mid-frame long enough for the optional abort
    send_byte(8'hD1, 2); send_byte(8'hD2, 0);
    idle(TIMEOUT_CYCLES + 20);
    chk("timeout_pulses", to_seen, m_to_exp);
    check_levels("after_stall");
    send_byte(8'hC1, 2);
    while (!m_hold) send_byte(8'($urandom_range(0, 255)), 2);
    pulse_done(1'b0, 8'h00);

    // reset mid-frame discards the partial frame
    send_byte(8'hE1, 2); send_byte(8'hE2, 2);
    do_reset();
    send_byte(8'hF1, 2); send_byte(8'hF2, 2); send_byte(8'hF3, 2); send_byte(8'hF4, 2);

    idle(5);
    chk("pending_writes", exp_q.size(), 0);
    chk("timeout_pulses_final", to_seen, m_to_exp);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
